// File: rtl/seven_seg_capture_if.sv
// rtl/seven_seg_capture_if.sv - multiplexed seven-segment capture bus
interface seven_seg_capture_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   enable_in;
  logic [4*DIGITS-1:0] value;
  logic                frame_valid;
  logic                seg_err;
  logic [DIGITS-1:0]   blank_mask;
  logic                stale;

  modport master (
    output seg_in, enable_in,
    input  value, frame_valid, seg_err, blank_mask, stale
  );

  modport slave (
    input  seg_in, enable_in,
    output value, frame_valid, seg_err, blank_mask, stale
  );
endinterface

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - decodes a multiplexed 7-segment bus back into a hex word
module seven_seg_capture #(
  parameter int DIGITS         = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  seven_seg_capture_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
  localparam state_t FIRST = (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;

  // {legal, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = {2'b10, 4'h0};
      7'b1001111: decode = {2'b10, 4'h1};
      7'b0010010: decode = {2'b10, 4'h2};
      7'b0000110: decode = {2'b10, 4'h3};
      7'b1001100: decode = {2'b10, 4'h4};
      7'b0100100: decode = {2'b10, 4'h5};
      7'b0100000: decode = {2'b10, 4'h6};
      7'b0001111: decode = {2'b10, 4'h7};
      7'b0000000: decode = {2'b10, 4'h8};
      7'b0001100: decode = {2'b10, 4'h9};
      7'b0001000: decode = {2'b10, 4'hA};
      7'b1100000: decode = {2'b10, 4'hB};
      7'b0110001: decode = {2'b10, 4'hC};
      7'b1000010: decode = {2'b10, 4'hD};
      7'b0110000: decode = {2'b10, 4'hE};
      7'b0111000: decode = {2'b10, 4'hF};
      7'b1111111: decode = {2'b11, 4'h0};
      default:    decode = {2'b00, 4'h0};
    endcase
  endfunction

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       tmo;
  logic [DIGITS-1:0]   en_q, en_p;
  logic [6:0]          seg_q, seg_p;
  logic [DIGITS-1:0]   seen;
  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   blank_sh;
  logic [4*DIGITS-1:0] value_r;
  logic [DIGITS-1:0]   blank_r;
  logic                frame_valid_r, seg_err_r, stale_r;

  logic                changed, onehot;
  logic [IW-1:0]       cap_idx;
  logic [5:0]          dec;
  logic [DIGITS-1:0]   seen_m, blank_m;
  logic [4*DIGITS-1:0] shadow_m;
  logic [TW-1:0]       tmo_inc;
  state_t              rs_state;
  logic [CW-1:0]       rs_cnt;

  // The delayed sample (en_p, seg_p) is exactly what the FSM judged stable
  // on the edge that entered CAPTURE, so it doubles as the capture latch.
  always_comb begin
    changed = (en_q != en_p) || (seg_q != seg_p);
    onehot  = $onehot(~en_q);
    cap_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!en_p[i]) cap_idx = IW'(i);
    end
    dec      = decode(seg_p);
    seen_m   = seen | (DIGITS'(1) << cap_idx);
    shadow_m = shadow;
    shadow_m[4*int'(cap_idx) +: 4] = dec[3:0];
    blank_m  = blank_sh;
    blank_m[cap_idx] = dec[4];
    tmo_inc  = (tmo == TMAX) ? tmo : tmo + TW'(1);
    rs_state = onehot ? FIRST : IDLE;
    rs_cnt   = onehot ? CW'(1) : CW'(0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= '1;
      en_p  <= '1;
      seg_q <= '1;
      seg_p <= '1;
    end else begin
      en_q  <= bus.enable_in;
      seg_q <= bus.seg_in;
      en_p  <= en_q;
      seg_p <= seg_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      tmo           <= '0;
      seen          <= '0;
      shadow        <= '0;
      blank_sh      <= '0;
      value_r       <= '0;
      blank_r       <= '0;
      frame_valid_r <= 1'b0;
      seg_err_r     <= 1'b0;
      stale_r       <= 1'b1;
    end else begin
      frame_valid_r <= 1'b0;
      seg_err_r     <= 1'b0;
      tmo           <= tmo_inc;
      if (tmo_inc == TMAX) stale_r <= 1'b1;

      case (state)
        IDLE: begin
          state <= rs_state;
          cnt   <= rs_cnt;
        end
        SETTLE: begin
          if (!changed) begin
            cnt <= cnt + CW'(1);
            if (int'(cnt) + 1 == SETTLE_CYCLES) state <= CAPTURE;
          end else begin
            state <= rs_state;
            cnt   <= rs_cnt;
          end
        end
        CAPTURE: begin
          if (dec[5]) begin
            tmo      <= '0;
            stale_r  <= 1'b0;
            shadow   <= shadow_m;
            blank_sh <= blank_m;
            if (&seen_m) begin
              value_r       <= shadow_m;
              blank_r       <= blank_m;
              frame_valid_r <= 1'b1;
              seen          <= '0;
            end else begin
              seen <= seen_m;
            end
          end else begin
            seg_err_r <= 1'b1;
          end
          // A new pattern arriving during the capture cycle still counts.
          if (changed) begin
            state <= rs_state;
            cnt   <= rs_cnt;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (changed) begin
            state <= rs_state;
            cnt   <= rs_cnt;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.value       = value_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.seg_err     = seg_err_r;
  assign bus.blank_mask  = blank_r;
  assign bus.stale       = stale_r;
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - scoreboard bench for seven_seg_capture
module tb_seven_seg_capture;
  localparam int D = 4;
  localparam int S = 4;
  localparam int T = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_capture_if #(.DIGITS(D)) bus ();

  seven_seg_capture #(.DIGITS(D), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [6:0] codes [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  typedef struct {
    bit          is_err;
    logic [15:0] val;
    logic [3:0]  bl;
  } ev_t;
  ev_t expq[$];

  int tests = 0;
  int failed = 0;

  logic [3:0] m_nib  [D];
  bit         m_blank[D];
  bit         m_seen [D];
  logic [D-1:0] last_en = '1;
  logic [6:0]   last_seg = 7'h7F;

  // -1 illegal, 16 blank, else the hex digit
  function automatic int decode_ref(logic [6:0] s);
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    if (s == 7'h7F) return 16;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_seen[i] = 0;
  endtask

  // A one-hot pattern held for at least S cycles is captured exactly once.
  task automatic drive(logic [D-1:0] en, logic [6:0] seg, int h);
    int lows, d, idx;
    ev_t e;
    bit all;
    lows = 0;
    idx = 0;
    for (int i = 0; i < D; i++) if (!en[i]) begin lows++; idx = i; end
    if (lows == 1 && h >= S) begin
      d = decode_ref(seg);
      if (d < 0) begin
        e.is_err = 1; e.val = '0; e.bl = '0;
        expq.push_back(e);
      end else begin
        m_nib[idx]   = (d == 16) ? 4'h0 : 4'(d);
        m_blank[idx] = (d == 16);
        m_seen[idx]  = 1;
        all = 1;
        for (int i = 0; i < D; i++) all &= m_seen[i];
        if (all) begin
          e.is_err = 0;
          for (int i = 0; i < D; i++) begin
            e.val[4*i +: 4] = m_nib[i];
            e.bl[i] = m_blank[i];
          end
          expq.push_back(e);
          model_reset();
        end
      end
    end
    bus.enable_in = en;
    bus.seg_in = seg;
    last_en = en;
    last_seg = seg;
    repeat (h) @(posedge clk);
    #1;
  endtask

  task automatic idle(int h);
    drive('1, 7'h7F, h);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(expq.size()), 0);
    expq.delete();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, ".value"}, 32'(bus.value), 0);
    check({tag, ".frame_valid"}, 32'(bus.frame_valid), 0);
    check({tag, ".seg_err"}, 32'(bus.seg_err), 0);
    check({tag, ".blank_mask"}, 32'(bus.blank_mask), 0);
    check({tag, ".stale"}, 32'(bus.stale), 1);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst && (bus.frame_valid || bus.seg_err)) begin
      tests++;
      if (expq.size() == 0) begin
        failed++;
        $display("FAIL unexpected_event: frame_valid=%0b seg_err=%0b value=%0h, none expected",
                 bus.frame_valid, bus.seg_err, bus.value);
      end else begin
        e = expq.pop_front();
        if (e.is_err) begin
          if (!bus.seg_err || bus.frame_valid) begin
            failed++;
            $display("FAIL seg_err_event: got frame_valid=%0b seg_err=%0b expected seg_err only",
                     bus.frame_valid, bus.seg_err);
          end
        end else if (!bus.frame_valid || bus.seg_err || bus.value !== e.val || bus.blank_mask !== e.bl) begin
          failed++;
          $display("FAIL frame_event: got fv=%0b err=%0b value=%0h blank=%0b expected value=%0h blank=%0b",
                   bus.frame_valid, bus.seg_err, bus.value, bus.blank_mask, e.val, e.bl);
        end
      end
    end
  end

  initial begin
    logic [D-1:0] en;
    logic [6:0] seg;
    int r;
    bus.enable_in = '1;
    bus.seg_in = 7'h7F;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // basic scan 1,2,3,4
    drive(4'b1110, codes[1], 8);
    drive(4'b1101, codes[2], 8);
    drive(4'b1011, codes[3], 8);
    drive(4'b0111, codes[4], 8);
    idle(10);
    drain();
    check("scan.value", 32'(bus.value), 32'h4321);
    check("scan.blank", 32'(bus.blank_mask), 0);
    check("scan.stale", 32'(bus.stale), 0);

    // too-short holds are never captured
    drive(4'b1110, codes[5], S - 1);
    drive(4'b1101, codes[6], S - 1);
    drive(4'b1011, codes[5], S - 1);
    drive(4'b0111, codes[6], S - 1);
    idle(10);
    drain();
    check("short.value", 32'(bus.value), 32'h4321);

    // illegal pattern on digit 2, then legal rescan
    drive(4'b1110, codes[7], 8);
    drive(4'b1101, codes[8], 8);
    drive(4'b1011, 7'b1111110, 8);
    drive(4'b0111, codes[9], 8);
    idle(10);
    drive(4'b1011, codes[10], 8);
    idle(10);
    drain();
    check("illegal.digit2", 32'(bus.value[11:8]), 32'hA);

    // multi-hot and no-hot enables mid-scan, blank digit
    drive(4'b1110, codes[1], 8);
    drive(4'b1101, codes[2], 8);
    drive(4'b1100, codes[3], 20);
    drive(4'b1111, codes[3], 20);
    drive(4'b1011, 7'h7F, 8);
    drive(4'b0111, codes[15], 8);
    idle(10);
    drain();
    check("nonhot.value", 32'(bus.value), 32'hF021);
    check("nonhot.blank", 32'(bus.blank_mask), 32'b0100);

    // timeout
    idle(T + 5);
    check("timeout.stale", 32'(bus.stale), 1);
    drive(4'b1110, codes[3], 8);
    check("timeout.clear", 32'(bus.stale), 0);

    // reset aborts a partial frame
    drive(4'b1101, codes[1], 8);
    drive(4'b1011, codes[2], 8);
    idle(10);
    drain();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    rst = 1'b0;
    drive(4'b0111, codes[4], 8);
    idle(10);
    drain();

    // randomized scans
    for (int k = 0; k < 120; k++) begin
      do begin
        if ($urandom_range(0, 4) != 0) en = ~(D'(1) << $urandom_range(0, D - 1));
        else en = D'($urandom);
        r = $urandom_range(0, 19);
        if (r < 14) seg = codes[$urandom_range(0, 15)];
        else if (r < 16) seg = 7'h7F;
        else begin
          do seg = 7'($urandom); while (decode_ref(seg) != -1);
        end
      end while (en == last_en && seg == last_seg);
      drive(en, seg, $urandom_range(1, S + 4));
    end
    idle(10);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
